// File: rtl/pipe_pkg.sv
// Shared types and helpers for the valid/stall pipeline chain: stage styles and
// their per-stage latency and capacity.
package pipe_pkg;

    typedef enum logic [1:0] {
        PIPE_SV  = 2'd0,
        PIPE_SS  = 2'd1,
        PIPE_SVS = 2'd2,
        PIPE_SSV = 2'd3
    } pipe_mode_e;

    function automatic int unsigned pipe_lat(input pipe_mode_e mode);
        case (mode)
            PIPE_SS: return 32'd0;
            default: return 32'd1;
        endcase
    endfunction

    function automatic int unsigned pipe_cap(input pipe_mode_e mode);
        case (mode)
            PIPE_SV: return 32'd1;
            PIPE_SS: return 32'd1;
            default: return 32'd2;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: a registered valid/data element and/or a skid element,
// ordered according to MODE. Both elements honour a synchronous flush.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int         WIDTH = 32,
    parameter pipe_mode_e MODE  = PIPE_SVS
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_stall,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_stall,
    output logic [1:0]       occ
);

    logic             sv_in_valid;
    logic [WIDTH-1:0] sv_in_data;
    logic             sv_in_stall;
    logic             sv_out_stall;
    logic             sv_valid_d;
    logic             sv_valid_q;
    logic [WIDTH-1:0] sv_data_d;
    logic [WIDTH-1:0] sv_data_q;

    logic             sk_in_valid;
    logic [WIDTH-1:0] sk_in_data;
    logic             sk_in_stall;
    logic             sk_out_valid;
    logic [WIDTH-1:0] sk_out_data;
    logic             sk_out_stall;
    logic             sk_set;
    logic             sk_clr;
    logic             sk_valid_d;
    logic             sk_valid_q;
    logic [WIDTH-1:0] sk_data_d;
    logic [WIDTH-1:0] sk_data_q;

    assign sv_in_stall = sv_valid_q & sv_out_stall;

    // Registered element: load when not stalled, data only on an actual transfer.
    always_comb begin
        sv_valid_d = sv_valid_q;
        sv_data_d  = sv_data_q;
        if (flush) begin
            sv_valid_d = 1'b0;
        end else if (!sv_in_stall) begin
            sv_valid_d = sv_in_valid;
            if (sv_in_valid) begin
                sv_data_d = sv_in_data;
            end else begin
                sv_data_d = sv_data_q;
            end
        end else begin
            sv_valid_d = sv_valid_q;
        end
    end

    assign sk_set       = sk_in_valid & ~sk_valid_q & sk_out_stall;
    assign sk_clr       = sk_valid_q & ~sk_out_stall;
    assign sk_in_stall  = sk_valid_q;
    assign sk_out_valid = sk_valid_q | sk_in_valid;
    assign sk_out_data  = sk_valid_q ? sk_data_q : sk_in_data;

    // Skid element: capture when downstream stalls an accepted beat, release when it frees.
    always_comb begin
        sk_valid_d = sk_valid_q;
        sk_data_d  = sk_data_q;
        if (flush) begin
            sk_valid_d = 1'b0;
        end else if (sk_set) begin
            sk_valid_d = 1'b1;
            sk_data_d  = sk_in_data;
        end else if (sk_clr) begin
            sk_valid_d = 1'b0;
        end else begin
            sk_valid_d = sk_valid_q;
        end
    end

    // Count reported ahead of the edge so the chain-level register tracks held entries exactly.
    assign occ = {1'b0, sv_valid_d} + {1'b0, sk_valid_d};

    // Element ordering; an absent element has its input tied idle so it stays empty.
    case (MODE)
        PIPE_SV: begin : g_sv
            assign sv_in_valid  = in_valid;
            assign sv_in_data   = in_data;
            assign sv_out_stall = out_stall;
            assign sk_in_valid  = 1'b0;
            assign sk_in_data   = {WIDTH{1'b0}};
            assign sk_out_stall = 1'b0;
            assign in_stall     = sv_in_stall;
            assign out_valid    = sv_valid_q;
            assign out_data     = sv_data_q;
        end
        PIPE_SS: begin : g_ss
            assign sv_in_valid  = 1'b0;
            assign sv_in_data   = {WIDTH{1'b0}};
            assign sv_out_stall = 1'b0;
            assign sk_in_valid  = in_valid;
            assign sk_in_data   = in_data;
            assign sk_out_stall = out_stall;
            assign in_stall     = sk_in_stall;
            assign out_valid    = sk_out_valid;
            assign out_data     = sk_out_data;
        end
        PIPE_SSV: begin : g_ssv
            assign sk_in_valid  = in_valid;
            assign sk_in_data   = in_data;
            assign sk_out_stall = sv_in_stall;
            assign sv_in_valid  = sk_out_valid;
            assign sv_in_data   = sk_out_data;
            assign sv_out_stall = out_stall;
            assign in_stall     = sk_in_stall;
            assign out_valid    = sv_valid_q;
            assign out_data     = sv_data_q;
        end
        default: begin : g_svs
            assign sv_in_valid  = in_valid;
            assign sv_in_data   = in_data;
            assign sv_out_stall = sk_in_stall;
            assign sk_in_valid  = sv_valid_q;
            assign sk_in_data   = sv_data_q;
            assign sk_out_stall = out_stall;
            assign in_stall     = sv_in_stall;
            assign out_valid    = sk_out_valid;
            assign out_data     = sk_out_data;
        end
    endcase

    // Stage state registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sv_valid_q <= 1'b0;
            sv_data_q  <= {WIDTH{1'b0}};
            sk_valid_q <= 1'b0;
            sk_data_q  <= {WIDTH{1'b0}};
        end else begin
            sv_valid_q <= sv_valid_d;
            sv_data_q  <= sv_data_d;
            sk_valid_q <= sk_valid_d;
            sk_data_q  <= sk_data_d;
        end
    end

endmodule

// File: rtl/pipe_chain.sv
// DEPTH cascaded pipe_stage instances with a synchronous flush and a registered
// count of entries held anywhere in the chain.
module pipe_chain
    import pipe_pkg::*;
#(
    parameter int         WIDTH = 32,
    parameter int         DEPTH = 1,
    parameter pipe_mode_e MODE  = PIPE_SVS
) (
    input  logic                           clk,
    input  logic                           arst_n,
    input  logic                           i_valid,
    input  logic [WIDTH-1:0]               i_data,
    output logic                           i_stall,
    output logic                           o_valid,
    output logic [WIDTH-1:0]               o_data,
    input  logic                           o_stall,
    input  logic                           flush,
    output logic [$clog2(2*DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(2*DEPTH+1);

    logic [1:0]       stage_occ [DEPTH];
    logic [OCC_W-1:0] occupancy_d;
    logic [OCC_W-1:0] occupancy_q;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             in_valid;
        logic [WIDTH-1:0] in_data;
        logic             in_stall;
        logic             out_valid;
        logic [WIDTH-1:0] out_data;
        logic             out_stall;

        if (k == 0) begin : g_head
            assign in_valid = i_valid;
            assign in_data  = i_data;
        end else begin : g_link
            assign in_valid = g_stage[k-1].out_valid;
            assign in_data  = g_stage[k-1].out_data;
        end

        if (k == DEPTH - 1) begin : g_tail
            assign out_stall = o_stall;
        end else begin : g_back
            assign out_stall = g_stage[k+1].in_stall;
        end

        pipe_stage #(
            .WIDTH (WIDTH),
            .MODE  (MODE)
        ) u_stage (
            .clk       (clk),
            .arst_n    (arst_n),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_data   (in_data),
            .in_stall  (in_stall),
            .out_valid (out_valid),
            .out_data  (out_data),
            .out_stall (out_stall),
            .occ       (stage_occ[k])
        );
    end

    // During flush the upstream beat is swallowed and nothing is offered downstream.
    assign i_stall   = flush ? 1'b0 : g_stage[0].in_stall;
    assign o_valid   = flush ? 1'b0 : g_stage[DEPTH-1].out_valid;
    assign o_data    = g_stage[DEPTH-1].out_data;
    assign occupancy = occupancy_q;

    // Sum of the next-edge held counts of every stage.
    always_comb begin
        occupancy_d = {OCC_W{1'b0}};
        if (flush) begin
            occupancy_d = {OCC_W{1'b0}};
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                occupancy_d = occupancy_d + OCC_W'(stage_occ[k]);
            end
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            occupancy_q <= {OCC_W{1'b0}};
        end else begin
            occupancy_q <= occupancy_d;
        end
    end

endmodule

// File: tb/tb_pipe_chain.sv
// Bench for pipe_chain: several configurations side by side sharing one input
// stream, each with its own downstream stall and scoreboard queue.
module tb_pipe_chain;
    import pipe_pkg::*;

    localparam int N = 11;
    localparam pipe_mode_e CFG_MODE [N] = '{PIPE_SV, PIPE_SVS, PIPE_SS, PIPE_SSV,
                                            PIPE_SV, PIPE_SV, PIPE_SS, PIPE_SVS,
                                            PIPE_SVS, PIPE_SSV, PIPE_SSV};
    localparam int CFG_DEPTH [N] = '{3, 2, 1, 2, 1, 4, 4, 1, 4, 1, 4};
    localparam int I_STREAM = 0;
    localparam int I_SVS2   = 1;
    localparam int I_SKID   = 2;
    localparam int I_FLUSH  = 3;

    logic         clk = 1'b0;
    logic         arst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic [7:0]   i_data = 8'h00;
    logic         flush = 1'b0;
    logic [N-1:0] o_stall_v = '0;
    logic [N-1:0] i_stall_v;
    logic [N-1:0] o_valid_v;
    logic [7:0]   o_data_a [N];
    logic [3:0]   occ_a [N];

    logic [7:0]   sbq [N][$];
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int OW = $clog2(2*CFG_DEPTH[g]+1);
        logic [OW-1:0] occ_w;
        pipe_chain #(
            .WIDTH (8),
            .DEPTH (CFG_DEPTH[g]),
            .MODE  (CFG_MODE[g])
        ) u_dut (
            .clk       (clk),
            .arst_n    (arst_n),
            .i_valid   (i_valid),
            .i_data    (i_data),
            .i_stall   (i_stall_v[g]),
            .o_valid   (o_valid_v[g]),
            .o_data    (o_data_a[g]),
            .o_stall   (o_stall_v[g]),
            .flush     (flush),
            .occupancy (occ_w)
        );
        assign occ_a[g] = 4'(occ_w);
    end

    task automatic do_reset();
        @(negedge clk);
        arst_n = 1'b0; i_valid = 1'b0; i_data = 8'h00; o_stall_v = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < N; i++) sbq[i].delete();
    endtask

    // One cycle of stimulus; returns just after inputs settle, well before the rising edge.
    task automatic cyc(input logic v, input logic [7:0] d, input logic [N-1:0] os, input logic fl);
        @(negedge clk);
        i_valid = v; i_data = d; o_stall_v = os; flush = fl;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (o_valid_v[i] !== 1'b0 || i_stall_v[i] !== 1'b0 || occ_a[i] !== 4'd0 || o_data_a[i] !== 8'h00) begin
                failures++;
                $display("FAIL reset_state inst=%0d got v=%b s=%b occ=%0d d=%h exp 0/0/0/00",
                         i, o_valid_v[i], i_stall_v[i], occ_a[i], o_data_a[i]);
            end
        end
        cyc(1'b1, 8'h11, '1, 1'b0);
        cyc(1'b1, 8'h12, '1, 1'b0);
        cyc(1'b1, 8'h13, '1, 1'b0);
        cyc(1'b0, 8'h00, '1, 1'b0);
        checks++;
        if (occ_a[I_SVS2] !== 4'd3 || o_valid_v[I_SVS2] !== 1'b1) begin
            failures++;
            $display("FAIL reset_prefill got occ=%0d v=%b exp occ=3 v=1", occ_a[I_SVS2], o_valid_v[I_SVS2]);
        end
        arst_n = 1'b0;
        #1;
        checks++;
        if (o_valid_v[I_SVS2] !== 1'b0 || i_stall_v[I_SVS2] !== 1'b0 || occ_a[I_SVS2] !== 4'd0) begin
            failures++;
            $display("FAIL reset_async got v=%b s=%b occ=%0d exp 0/0/0",
                     o_valid_v[I_SVS2], i_stall_v[I_SVS2], occ_a[I_SVS2]);
        end
        @(negedge clk);
        arst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cyc(1'b0, 8'h00, '0, 1'b0);
            checks++;
            if (o_valid_v[I_SVS2] !== 1'b0 || occ_a[I_SVS2] !== 4'd0) begin
                failures++;
                $display("FAIL reset_stale cyc=%0d got v=%b occ=%0d exp v=0 occ=0",
                         c, o_valid_v[I_SVS2], occ_a[I_SVS2]);
            end
        end
    endtask

    task automatic test_streaming();
        int lat;
        logic exp_v;
        logic [7:0] exp_d;
        lat = CFG_DEPTH[I_STREAM] * int'(pipe_lat(CFG_MODE[I_STREAM]));
        do_reset();
        for (int c = 0; c < 24; c++) begin
            cyc(c < 16, 8'(c + 1), '0, 1'b0);
            exp_v = (c >= lat) && (c < lat + 16);
            checks++;
            if (o_valid_v[I_STREAM] !== exp_v) begin
                failures++;
                $display("FAIL stream_valid cyc=%0d got=%b exp=%b", c, o_valid_v[I_STREAM], exp_v);
            end
            if (i_valid && !i_stall_v[I_STREAM]) sbq[I_STREAM].push_back(i_data);
            if (o_valid_v[I_STREAM]) begin
                checks++;
                if (sbq[I_STREAM].size() == 0) begin
                    failures++;
                    $display("FAIL stream_spurious cyc=%0d got=%h exp=none", c, o_data_a[I_STREAM]);
                end else begin
                    exp_d = sbq[I_STREAM].pop_front();
                    if (o_data_a[I_STREAM] !== exp_d) begin
                        failures++;
                        $display("FAIL stream_data cyc=%0d got=%h exp=%h", c, o_data_a[I_STREAM], exp_d);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int acc;
        do_reset();
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            cyc(1'b1, 8'hA0 + 8'(acc), '1, 1'b0);
            if (!i_stall_v[I_SVS2]) acc++;
        end
        checks++;
        if (acc != 4 || i_stall_v[I_SVS2] !== 1'b1 || occ_a[I_SVS2] !== 4'd4) begin
            failures++;
            $display("FAIL bp_fill got acc=%0d stall=%b occ=%0d exp acc=4 stall=1 occ=4",
                     acc, i_stall_v[I_SVS2], occ_a[I_SVS2]);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 8'h00, '0, 1'b0);
            checks++;
            if (o_valid_v[I_SVS2] !== 1'b1 || o_data_a[I_SVS2] !== 8'hA0 + 8'(k)) begin
                failures++;
                $display("FAIL bp_drain k=%0d got v=%b d=%h exp v=1 d=%h",
                         k, o_valid_v[I_SVS2], o_data_a[I_SVS2], 8'hA0 + 8'(k));
            end
        end
        cyc(1'b0, 8'h00, '0, 1'b0);
        checks++;
        if (o_valid_v[I_SVS2] !== 1'b0 || occ_a[I_SVS2] !== 4'd0) begin
            failures++;
            $display("FAIL bp_empty got v=%b occ=%0d exp v=0 occ=0", o_valid_v[I_SVS2], occ_a[I_SVS2]);
        end
    endtask

    task automatic test_skid();
        do_reset();
        cyc(1'b1, 8'hAA, '1, 1'b0);
        checks++;
        if (i_stall_v[I_SKID] !== 1'b0 || o_valid_v[I_SKID] !== 1'b1 || o_data_a[I_SKID] !== 8'hAA) begin
            failures++;
            $display("FAIL skid_capture got s=%b v=%b d=%h exp s=0 v=1 d=aa",
                     i_stall_v[I_SKID], o_valid_v[I_SKID], o_data_a[I_SKID]);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 8'hBB, '1, 1'b0);
            checks++;
            if (i_stall_v[I_SKID] !== 1'b1 || o_valid_v[I_SKID] !== 1'b1 ||
                o_data_a[I_SKID] !== 8'hAA || occ_a[I_SKID] !== 4'd1) begin
                failures++;
                $display("FAIL skid_hold k=%0d got s=%b v=%b d=%h occ=%0d exp s=1 v=1 d=aa occ=1",
                         k, i_stall_v[I_SKID], o_valid_v[I_SKID], o_data_a[I_SKID], occ_a[I_SKID]);
            end
        end
        cyc(1'b1, 8'hBB, '0, 1'b0);
        checks++;
        if (i_stall_v[I_SKID] !== 1'b1 || o_valid_v[I_SKID] !== 1'b1 || o_data_a[I_SKID] !== 8'hAA) begin
            failures++;
            $display("FAIL skid_release got s=%b v=%b d=%h exp s=1 v=1 d=aa",
                     i_stall_v[I_SKID], o_valid_v[I_SKID], o_data_a[I_SKID]);
        end
        cyc(1'b1, 8'hBB, '0, 1'b0);
        checks++;
        if (i_stall_v[I_SKID] !== 1'b0 || o_valid_v[I_SKID] !== 1'b1 ||
            o_data_a[I_SKID] !== 8'hBB || occ_a[I_SKID] !== 4'd0) begin
            failures++;
            $display("FAIL skid_bypass got s=%b v=%b d=%h occ=%0d exp s=0 v=1 d=bb occ=0",
                     i_stall_v[I_SKID], o_valid_v[I_SKID], o_data_a[I_SKID], occ_a[I_SKID]);
        end
        cyc(1'b0, 8'h00, '0, 1'b0);
        checks++;
        if (o_valid_v[I_SKID] !== 1'b0) begin
            failures++;
            $display("FAIL skid_idle got v=%b exp v=0", o_valid_v[I_SKID]);
        end
    endtask

    task automatic test_flush();
        int seen_at;
        do_reset();
        cyc(1'b1, 8'h31, '1, 1'b0);
        cyc(1'b1, 8'h32, '1, 1'b0);
        cyc(1'b1, 8'h33, '1, 1'b0);
        cyc(1'b0, 8'h00, '1, 1'b0);
        checks++;
        if (occ_a[I_FLUSH] !== 4'd3) begin
            failures++;
            $display("FAIL flush_prefill got occ=%0d exp occ=3", occ_a[I_FLUSH]);
        end
        cyc(1'b1, 8'h55, '0, 1'b1);
        checks++;
        if (o_valid_v[I_FLUSH] !== 1'b0 || i_stall_v[I_FLUSH] !== 1'b0) begin
            failures++;
            $display("FAIL flush_cycle got v=%b s=%b exp v=0 s=0", o_valid_v[I_FLUSH], i_stall_v[I_FLUSH]);
        end
        cyc(1'b0, 8'h00, '1, 1'b0);
        checks++;
        if (occ_a[I_FLUSH] !== 4'd0 || o_valid_v[I_FLUSH] !== 1'b0) begin
            failures++;
            $display("FAIL flush_after got occ=%0d v=%b exp occ=0 v=0", occ_a[I_FLUSH], o_valid_v[I_FLUSH]);
        end
        for (int c = 0; c < 6; c++) begin
            cyc(1'b0, 8'h00, '0, 1'b0);
            checks++;
            if (o_valid_v[I_FLUSH] !== 1'b0) begin
                failures++;
                $display("FAIL flush_leak cyc=%0d got v=1 d=%h exp v=0", c, o_data_a[I_FLUSH]);
            end
        end
        cyc(1'b1, 8'h66, '0, 1'b0);
        seen_at = -1;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 8'h00, '0, 1'b0);
            if (o_valid_v[I_FLUSH] === 1'b1) begin
                checks++;
                if (o_data_a[I_FLUSH] !== 8'h66 || seen_at != -1) begin
                    failures++;
                    $display("FAIL flush_resume_data k=%0d got=%h exp=66 once", k, o_data_a[I_FLUSH]);
                end
                seen_at = k;
            end
        end
        checks++;
        if (seen_at != 1) begin
            failures++;
            $display("FAIL flush_resume_latency got=%0d exp=1", seen_at);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_d;
        int cap;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            cyc(1'($urandom_range(0, 1)), 8'(c), N'($urandom), ($urandom_range(0, 127) == 0));
            for (int i = 0; i < N; i++) begin
                if (flush) begin
                    checks++;
                    if (o_valid_v[i] !== 1'b0 || i_stall_v[i] !== 1'b0) begin
                        failures++;
                        $display("FAIL rnd_flush inst=%0d cyc=%0d got v=%b s=%b exp 0/0", i, c, o_valid_v[i], i_stall_v[i]);
                    end
                    sbq[i].delete();
                end else begin
                    cap = int'(pipe_cap(CFG_MODE[i])) * CFG_DEPTH[i];
                    checks++;
                    if (int'(occ_a[i]) != sbq[i].size() || int'(occ_a[i]) > cap) begin
                        failures++;
                        $display("FAIL rnd_occ inst=%0d cyc=%0d got=%0d exp=%0d max=%0d", i, c, occ_a[i], sbq[i].size(), cap);
                    end
                    if (i_valid && !i_stall_v[i]) sbq[i].push_back(i_data);
                    if (o_valid_v[i] && !o_stall_v[i]) begin
                        checks++;
                        if (sbq[i].size() == 0) begin
                            failures++;
                            $display("FAIL rnd_dup inst=%0d cyc=%0d got=%h exp=none", i, c, o_data_a[i]);
                        end else begin
                            exp_d = sbq[i].pop_front();
                            if (o_data_a[i] !== exp_d) begin
                                failures++;
                                $display("FAIL rnd_data inst=%0d cyc=%0d got=%h exp=%h", i, c, o_data_a[i], exp_d);
                            end
                        end
                    end
                end
            end
        end
        for (int c = 0; c < 20; c++) begin
            cyc(1'b0, 8'h00, '0, 1'b0);
            for (int i = 0; i < N; i++) begin
                if (o_valid_v[i] && sbq[i].size() != 0) begin
                    exp_d = sbq[i].pop_front();
                    checks++;
                    if (o_data_a[i] !== exp_d) begin
                        failures++;
                        $display("FAIL rnd_drain inst=%0d got=%h exp=%h", i, o_data_a[i], exp_d);
                    end
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (sbq[i].size() != 0 || occ_a[i] !== 4'd0) begin
                failures++;
                $display("FAIL rnd_loss inst=%0d got left=%0d occ=%0d exp 0/0", i, sbq[i].size(), occ_a[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_skid();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_chain.md
Name: pipe_chain

Overview:
- Parametrised valid/stall pipeline of DEPTH identical stages.
- Each stage's register style is selected by MODE: plain valid/data register, skid buffer, or either ordering of the two.
- Adds two things the fixed-width single stages lack: a synchronous flush and an occupancy count.
- Sits between producer and consumer blocks for timing closure on valid, data and/or stall paths.

Parameters:
- WIDTH, 32: payload width in bits, >=1.
- DEPTH, 1: number of cascaded stages, 1..8.
- MODE, PIPE_SVS: per-stage style, of type pipe_mode_e:
  - PIPE_SV: registered valid/data.
  - PIPE_SS: skid on stall.
  - PIPE_SVS: valid/data register then skid.
  - PIPE_SSV: skid then valid/data register.

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  upstream valid.
- i_data  in  WIDTH  upstream payload.
- i_stall  out  1  backpressure to upstream.
- o_valid  out  1  downstream valid.
- o_data  out  WIDTH  downstream payload.
- o_stall  in  1  backpressure from downstream.
- flush  in  1  synchronous drop of all held entries.
- occupancy  out  $clog2(2*DEPTH+1)  number of entries currently held in registers.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low on arst_n. All valid and data flops reset to 0, so o_valid=0, o_data=0, i_stall=0, occupancy=0.
- Handshake:
  - A transfer occurs on an interface when valid=1 and stall=0 in the same cycle.
  - Data must not be lost or duplicated, and order is preserved.
  - A valid offered upstream need not be held while stalled; stages tolerate withdrawal.
- SV stage:
  - in_stall = out_valid & out_stall.
  - When !in_stall: valid register <= in_valid, and data register <= in_data if in_valid.
  - Data register holds when not loaded.
  - Latency 1; capacity 1.
- SS stage:
  - skid_set = in_valid & !skid_valid & out_stall.
  - skid_clr = skid_valid & !out_stall.
  - in_stall = skid_valid (registered only; no combinational stall path).
  - out_valid = skid_valid | in_valid; out_data = skid_valid ? skid_data : in_data.
  - Latency 0; capacity 1.
- SVS stage: SV register followed by SS. Latency 1; capacity 2.
- SSV stage: SS followed by SV register. Latency 1; capacity 2.
- Chain: stage k output feeds stage k+1 input.
  - Total latency with no stall = DEPTH*lat(MODE).
  - Maximum occupancy = DEPTH*cap(MODE).
- Throughput: 1 transfer per cycle sustained when o_stall=0, for all modes.
- occupancy:
  - Registered sum of all held valid bits (SV valid registers plus skid valids).
  - In PIPE_SS the combinational bypass path does not count.
  - Updates on the cycle after the change.
- flush:
  - In the flush cycle, o_valid is forced 0 and i_stall is forced 0.
  - Any i_valid in that cycle is accepted and discarded.
  - All valid and skid-valid flops clear at the next edge; data flops keep their values.
  - occupancy = 0 on the next cycle.
  - flush overrides every simultaneous set, clear or load.
- Simultaneous set/clear within a skid: impossible by construction (set requires !skid_valid, clear requires skid_valid). The next-state priority is still set, then clear, then hold.
- Reset mid-stream: all held entries are dropped immediately (asynchronous). No partial transfer is visible after release.
- X-safety: data flops load only on a transfer or on skid_set; o_data in an idle cycle is don't-care but deterministic.

Decomposition:
- pipe_pkg holds:
  - typedef enum pipe_mode_e {PIPE_SV, PIPE_SS, PIPE_SVS, PIPE_SSV}.
  - Functions pipe_lat(mode) and pipe_cap(mode).
- Sub-module pipe_stage (params WIDTH, MODE; ports as above plus flush and a local occ output of 0..2). It is instantiated DEPTH times in a generate loop.
- pipe_chain sums the stage occ outputs into a register.

Test Plan:
- Reset: assert arst_n=0 mid-stream with 3 items held (SVS, DEPTH=2) -> o_valid=0, i_stall=0 and occupancy=0 asynchronously; no stale item emitted after release.
- Streaming: MODE=SV, DEPTH=3, WIDTH=8, o_stall=0, inputs 0x01..0x10 back-to-back -> o_data 0x01 appears 3 cycles after its input, then one item per cycle in order.
- Full backpressure: MODE=SVS, DEPTH=2, o_stall=1 held, i_valid=1 continuously -> exactly 4 items accepted, then i_stall=1 and occupancy=4. Releasing o_stall drains 4 items in order at 1/cycle.
- Skid timing: MODE=SS, DEPTH=1, o_stall rises while 0xAA is presented -> 0xAA captured in the skid, i_stall=1 the next cycle. o_valid=1 with o_data=0xAA persists until o_stall=0.
- Flush: MODE=SSV, DEPTH=2, 3 items held, flush=1 for one cycle with i_valid=1 and data 0x55 -> o_valid=0 that cycle and occupancy=0 next cycle. 0x55 never appears at the output.
- Random: random i_valid/o_stall at 50% for 10k cycles in all four modes with DEPTH in {1,4} -> scoreboard sees no loss, duplication or reorder. occupancy matches the reference count every cycle and never exceeds DEPTH*cap.
